// File: rtl/genius_seq_loader_pkg.sv
// genius_pkg: shared definitions for the Genius sequence loader.
// Holds the one-hot color constants, the LFSR tap mask, the entropy
// mask, the default seed, the loader state encoding and the helper that
// maps a 2-bit color index to its one-hot code.
// Optional feature macro used by the loader: GENIUS_NO_REPEAT_EN.
package genius_pkg;

    localparam logic [3:0] COR_VERDE    = 4'b0001;
    localparam logic [3:0] COR_VERMELHO = 4'b0010;
    localparam logic [3:0] COR_AZUL     = 4'b0100;
    localparam logic [3:0] COR_AMARELO  = 4'b1000;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] ENTROPY_MASK = 16'h5A5A;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    function automatic logic [3:0] color_of(input logic [1:0] idx);
        logic [3:0] c;
        case (idx)
            2'b00:   c = COR_VERDE;
            2'b01:   c = COR_VERMELHO;
            2'b10:   c = COR_AZUL;
            default: c = COR_AMARELO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/genius_seq_loader_if.sv
// genius_seq_loader_if: groups the loader's control and memory bus.
// Signals:
//   start, random_mode, game_addr  - driven by control unit / game datapath
//   mem_addr, mem_we, mem_wdata    - sequence memory port
//   busy, game_grant, done         - ownership and completion status
// Modports: master (control/datapath side), slave (the loader).
interface genius_seq_loader_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              random_mode;
    logic [ADDR_W-1:0] game_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_wdata;
    logic              busy;
    logic              game_grant;
    logic              done;

    modport master (
        output start, random_mode, game_addr,
        input  mem_addr, mem_we, mem_wdata, busy, game_grant, done
    );

    modport slave (
        input  start, random_mode, game_addr,
        output mem_addr, mem_we, mem_wdata, busy, game_grant, done
    );
endinterface

// File: rtl/genius_seq_loader_lfsr.sv
// genius_lfsr16: 16-bit Galois LFSR with parallel load.
// Ports:
//   clock, reset      - clock, asynchronous active-high reset
//   load, load_value  - overwrite the register (has priority over step)
//   step              - advance one position using LFSR_TAPS
//   value             - current register contents
module genius_lfsr16
    import genius_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE = DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] load_value,
    output logic [15:0] value
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= load_value;
        end else if (step) begin
            value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
        end
    end

endmodule

// File: rtl/genius_seq_loader.sv
// genius_seq_loader: fills the Genius sequence memory with DEPTH one-hot
// colors, then returns the memory address port to the game datapath.
// Ports:
//   clock, reset - clock, asynchronous active-high reset
//   bus (slave)  - start/random_mode/game_addr in; mem_addr/mem_we/
//                  mem_wdata/busy/game_grant/done out
// Parameters: ADDR_W, DEPTH (<= 2**ADDR_W), LFSR_SEED (nonzero).
// Optional feature: define GENIUS_NO_REPEAT_EN to forbid two equal
// adjacent colors (the first word is never altered).
module genius_seq_loader
    import genius_pkg::*;
#(
    parameter int          ADDR_W    = 4,
    parameter int          DEPTH     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    genius_seq_loader_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       entropy;
    logic              mode_q;
    logic              mem_we_r;
    logic              busy_r;
    logic              done_r;

    logic [15:0]       lfsr_value;
    logic [15:0]       ent_mix;
    logic [15:0]       seed_value;
    logic [1:0]        raw_idx;
    logic [1:0]        wr_idx;

    // Free-running entropy source; the game start time makes it random.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entropy <= '0;
        end else begin
            entropy <= entropy + 16'd1;
        end
    end

    // A zero seed would lock the LFSR, so fall back to the default.
    assign ent_mix    = entropy ^ ENTROPY_MASK;
    assign seed_value = mode_q ? ((ent_mix == 16'h0000) ? DEFAULT_SEED : ent_mix)
                               : LFSR_SEED;

    genius_lfsr16 #(
        .RESET_VALUE(LFSR_SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (state == ST_SEED),
        .step       (state == ST_WRITE),
        .load_value (seed_value),
        .value      (lfsr_value)
    );

    assign raw_idx = lfsr_value[1:0];

`ifdef GENIUS_NO_REPEAT_EN
    logic [1:0] prev_idx;

    // Bump a repeated index to the next color; the LFSR itself is untouched.
    assign wr_idx = ((addr_cnt != '0) && (raw_idx == prev_idx)) ? (raw_idx + 2'd1)
                                                                : raw_idx;

    always_ff @(posedge clock) begin
        if (state == ST_WRITE) begin
            prev_idx <= wr_idx;
        end
    end
`else
    assign wr_idx = raw_idx;
`endif

    // Loader FSM; outputs are registered alongside the state so they
    // always match the state they belong to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr_cnt <= '0;
            mode_q   <= 1'b0;
            mem_we_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state  <= ST_SEED;
                        mode_q <= bus.random_mode;
                        busy_r <= 1'b1;
                    end
                end
                ST_SEED: begin
                    addr_cnt <= '0;
                    mem_we_r <= 1'b1;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (addr_cnt == LAST_ADDR) begin
                        mem_we_r <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    mem_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    // The game datapath drives the address only while the loader is idle.
    assign bus.mem_addr   = (state == ST_IDLE) ? bus.game_addr : addr_cnt;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_wdata  = mem_we_r ? color_of(wr_idx) : 4'b0000;
    assign bus.busy       = busy_r;
    assign bus.game_grant = ~busy_r;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_genius_seq_loader.sv
// Testbench for genius_seq_loader: scoreboard of expected (addr, color)
// writes, filled when a load is started and drained by a write monitor.
module tb_genius_seq_loader;
    import genius_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    genius_seq_loader_if #(.ADDR_W(ADDR_W)) bus();

    genius_seq_loader #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    logic [3:0]  cap[DEPTH];
    int          wr_cnt = 0;
    logic [15:0] ent_model;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference for the entropy count seen by the DUT.
    always @(posedge clock or posedge reset) begin
        if (reset) ent_model <= 16'h0000;
        else       ent_model <= ent_model + 16'd1;
    end

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clock) begin
        logic [7:0] e;
        if (!reset && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, e[7:4]);
                check("wr_data", bus.mem_wdata, e[3:0]);
            end
            check("wr_onehot", $countones(bus.mem_wdata), 1);
            cap[bus.mem_addr] = bus.mem_wdata;
            wr_cnt++;
        end
    end

    function automatic void push_seq(input logic [15:0] seed);
        logic [15:0] l;
        logic [1:0]  idx;
        logic [1:0]  prev;
        l    = seed;
        prev = 2'b00;
        for (int i = 0; i < DEPTH; i++) begin
            idx = l[1:0];
`ifdef GENIUS_NO_REPEAT_EN
            if (i != 0 && idx == prev) idx = idx + 2'd1;
`endif
            prev = idx;
            exp_q.push_back({4'(i), 4'(1 << idx)});
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
    endfunction

    function automatic logic [15:0] seed_for(input logic rm, input logic [15:0] ent);
        logic [15:0] m;
        m = ent ^ 16'h5A5A;
        if (!rm) return 16'hACE1;
        return (m == 16'h0000) ? 16'hACE1 : m;
    endfunction

    task automatic do_load(input logic rm, input string tag);
        int k;
        bit seen;
        wr_cnt = 0;
        @(negedge clock);
        bus.start       = 1'b1;
        bus.random_mode = rm;
        @(posedge clock);
        #1;
        bus.start       = 1'b0;
        bus.random_mode = ~rm;
        push_seq(seed_for(rm, ent_model));
        seen = 0;
        k    = 0;
        while (!seen && k < 40) begin
            @(negedge clock);
            k++;
            if (bus.done) seen = 1;
        end
        check({tag, "_done_cycle"}, seen ? k : 99, 18);
        @(negedge clock);
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_grant_after"}, bus.game_grant, 1);
        check({tag, "_we_after"}, bus.mem_we, 0);
        check({tag, "_write_count"}, wr_cnt, DEPTH);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [3:0] seq_a[DEPTH];
        logic [3:0] seq_r1[DEPTH];
        int diff;
        int rep;
        int k;

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.random_mode = 1'b0;
        bus.game_addr   = 4'h7;
        #1;
        check("rst_we", bus.mem_we, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.game_grant, 1);
        check("rst_done", bus.done, 0);
        check("rst_addr", bus.mem_addr, 4'h7);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Idle: the game address passes straight through.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("idle_addr", bus.mem_addr, 4'h7);
            check("idle_we", bus.mem_we, 0);
            check("idle_busy", bus.busy, 0);
            check("idle_grant", bus.game_grant, 1);
        end
        bus.game_addr = 4'h3;
        #1;
        check("idle_addr_change", bus.mem_addr, 4'h3);

        // Fixed mode, twice: same sequence both times.
        do_load(1'b0, "fix1");
        seq_a = cap;
        check("fix_addr0", seq_a[0], 4'b0010);
        check("fix_addr1", seq_a[1], 4'b0001);
        rep = 0;
        for (int i = 1; i < DEPTH; i++) if (seq_a[i] == seq_a[i-1]) rep++;
`ifdef GENIUS_NO_REPEAT_EN
        check("fix_addr2", seq_a[2], 4'b0010);
        check("no_repeat", rep, 0);
`else
        check("fix_addr2", seq_a[2], 4'b0001);
        check("repeat_present", (rep > 0), 1);
`endif
        do_load(1'b0, "fix2");
        for (int i = 0; i < DEPTH; i++) check("fix_same", cap[i], seq_a[i]);

        // Random mode at two different entropy counts.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (99) @(negedge clock);
        do_load(1'b1, "rnd1");
        seq_r1 = cap;
        k = 0;
        while (ent_model < 16'd355 && k < 1000) begin
            @(negedge clock);
            k++;
        end
        do_load(1'b1, "rnd2");
        diff = 0;
        for (int i = 0; i < DEPTH; i++) if (cap[i] != seq_r1[i]) diff++;
        check("rnd_differ", (diff > 0), 1);

        // start held through the load, then reset on the 5th write.
        wr_cnt = 0;
        @(negedge clock);
        bus.start       = 1'b1;
        bus.random_mode = 1'b0;
        @(posedge clock);
        #1;
        push_seq(16'hACE1);
        k = 0;
        while (wr_cnt < 5 && k < 40) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("mid_5th_write", wr_cnt, 5);
        reset = 1'b1;
        #1;
        check("mid_rst_we", bus.mem_we, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_grant", bus.game_grant, 1);
        check("mid_rst_addr", bus.mem_addr, 4'h3);
        exp_q.delete();
        @(negedge clock);
        bus.start = 1'b0;
        reset     = 1'b0;
        do_load(1'b0, "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
